pdp8_nibble_bus_responder: RTL and testbench

- Target end of the PDP-8 CPU's 8-bit nibble bus; combines memory and I/O responder.
- Decodes the CPU's strobe/address/data byte stream and returns read nibbles on the CPU's 4-bit data input. Holds a local 12-bit-word RAM and forwards IOT beats to an external device port.
- Sits between the CPU's bus output and its data inputs (io_in[7:4] and io_in[0] ready during IO).

---
 rtl/pdp8_nibble_bus_responder.sv | 168 ++++++++++++++++
 tb/tb_pdp8_nibble_bus_responder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pdp8_nibble_bus_responder.sv
// PDP-8 nibble-bus target: decodes the CPU byte stream, serves a local 12-bit RAM
// and forwards IOT transfers to a device port. Optional write protect: PDP8_BUS_WRPROT_EN.
module pdp8_nibble_bus_responder #(
  parameter int MEM_WORDS = 256,
  parameter int WP_LIMIT  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  bus_in,
  output logic [3:0]  data_out,
  output logic [4:0]  io_dev,
  input  logic        io_ready,
  input  logic [11:0] io_rdata,
  output logic        io_rd,
  output logic        io_wr,
  output logic [11:0] io_wdata,
  output logic        bus_err
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_AHI, S_ADDR, S_IOC, S_DM, S_DL
  } state_t;

  state_t state, next_state;

  logic [11:0] mem [MEM_WORDS];
  logic [11:0] addr;
  logic [11:0] rd_word;
  logic [3:0]  wr_hi, wr_mid;
  logic        io_mode;

  logic        is_ahi, is_alo, is_ioc, is_dat, wbit;
  logic [1:0]  nib;
  logic [11:0] alo_addr, commit_word;
  logic [AW-1:0] rd_idx, wr_idx;

  logic err_set, ld_ahi, ld_alo, ld_io, ld_hi, ld_mid, mem_we;

  assign is_ahi = (bus_in[7:6] == 2'b10);
  assign is_alo = (bus_in[7:6] == 2'b11);
  assign is_ioc = (bus_in[7:5] == 3'b011);
  assign is_dat = !bus_in[7] && (bus_in[6:5] != 2'b11);
  assign nib    = bus_in[6:5];
  assign wbit   = bus_in[4];

  assign alo_addr    = {addr[11:6], bus_in[5:0]};
  assign rd_idx      = alo_addr[AW-1:0];
  assign wr_idx      = addr[AW-1:0];
  assign commit_word = {wr_hi, wr_mid, bus_in[3:0]};
  assign io_wdata    = io_wr ? commit_word : '0;

  // Address bits above the RAM depth are deliberately ignored (aliasing).
  logic unused_bits;
  assign unused_bits = ^{addr, 1'(WP_LIMIT)};

  always_comb begin
    next_state = state;
    err_set    = 1'b0;
    ld_ahi     = 1'b0;
    ld_alo     = 1'b0;
    ld_io      = 1'b0;
    ld_hi      = 1'b0;
    ld_mid     = 1'b0;
    mem_we     = 1'b0;
    io_rd      = 1'b0;
    io_wr      = 1'b0;
    data_out   = 4'h0;
    if (is_ahi) begin
      next_state = S_AHI;
      ld_ahi     = 1'b1;
    end else begin
      case (state)
        S_IDLE: err_set = 1'b1;
        S_AHI: begin
          if (is_alo) begin
            ld_alo     = 1'b1;
            next_state = S_ADDR;
          end else begin
            err_set = 1'b1;
          end
        end
        S_ADDR, S_IOC: begin
          if (state == S_ADDR && is_ioc) begin
            ld_io      = 1'b1;
            next_state = S_IOC;
            data_out   = {3'b000, io_ready};
          end else if (is_dat && nib == 2'b00) begin
            ld_hi      = 1'b1;
            next_state = S_DM;
            if (!wbit) data_out = rd_word[11:8];
          end else begin
            err_set = 1'b1;
          end
        end
        S_DM: begin
          if (is_dat && nib == 2'b01) begin
            ld_mid     = 1'b1;
            next_state = S_DL;
            if (!wbit) data_out = rd_word[7:4];
          end else begin
            err_set = 1'b1;
          end
        end
        S_DL: begin
          if (is_dat && nib == 2'b10) begin
            next_state = S_IDLE;
            if (wbit) begin
              if (io_mode) begin
                io_wr = 1'b1;
              end else begin
`ifdef PDP8_BUS_WRPROT_EN
                if (int'(wr_idx) < WP_LIMIT) err_set = 1'b1;
                else mem_we = 1'b1;
`else
                mem_we = 1'b1;
`endif
              end
            end else begin
              data_out = rd_word[3:0];
              io_rd    = io_mode;
            end
          end else begin
            err_set = 1'b1;
          end
        end
        default: err_set = 1'b1;
      endcase
      if (err_set) next_state = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      addr    <= '0;
      rd_word <= '0;
      wr_hi   <= '0;
      wr_mid  <= '0;
      io_mode <= 1'b0;
      io_dev  <= '0;
      bus_err <= 1'b0;
    end else begin
      state <= next_state;
      if (ld_ahi) addr[11:6] <= bus_in[5:0];
      if (ld_alo) begin
        addr[5:0] <= bus_in[5:0];
        rd_word   <= mem[rd_idx];
        io_mode   <= 1'b0;
      end
      if (ld_io) begin
        io_dev  <= bus_in[4:0];
        rd_word <= io_rdata;
        io_mode <= 1'b1;
      end
      if (ld_hi)   wr_hi   <= bus_in[3:0];
      if (ld_mid)  wr_mid  <= bus_in[3:0];
      if (err_set) bus_err <= 1'b1;
    end
  end

  // RAM has no reset so it can map onto block memory.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_idx] <= commit_word;
  end

endmodule

// File: tb/tb_pdp8_nibble_bus_responder.sv
// Directed scoreboard bench for pdp8_nibble_bus_responder (default build).
module tb_pdp8_nibble_bus_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  bus_in = 8'h00;
  logic [3:0]  data_out;
  logic [4:0]  io_dev;
  logic        io_ready = 1'b0;
  logic [11:0] io_rdata = 12'h000;
  logic        io_rd, io_wr;
  logic [11:0] io_wdata;
  logic        bus_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [3:0]  d;
    logic        rd;
    logic        wr;
    logic [11:0] wd;
  } exp_t;

  exp_t exp_q[$];

  pdp8_nibble_bus_responder #(.MEM_WORDS(256), .WP_LIMIT(16)) dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .data_out(data_out),
    .io_dev(io_dev), .io_ready(io_ready), .io_rdata(io_rdata),
    .io_rd(io_rd), .io_wr(io_wr), .io_wdata(io_wdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus_in = b;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic beat(input string tag, input logic [7:0] b, input logic [3:0] d,
                      input logic rd, input logic wr, input logic [11:0] wd);
    exp_t e;
    bus_in = b;
    exp_q.push_back('{tag, d, rd, wr, wd});
    @(negedge clk);
    e = exp_q.pop_front();
    check({e.tag, ".data_out"}, 12'(data_out), 12'(e.d));
    check({e.tag, ".io_rd"}, 12'(io_rd), 12'(e.rd));
    check({e.tag, ".io_wr"}, 12'(io_wr), 12'(e.wr));
    if (e.wr) check({e.tag, ".io_wdata"}, io_wdata, e.wd);
    @(posedge clk); #1;
  endtask

  task automatic wr_mem(input string tag, input logic [11:0] a, input logic [11:0] w);
    send({2'b10, a[11:6]});
    send({2'b11, a[5:0]});
    beat(tag, {4'b0001, w[11:8]}, 4'h0, 1'b0, 1'b0, 12'h0);
    beat(tag, {4'b0011, w[7:4]},  4'h0, 1'b0, 1'b0, 12'h0);
    beat(tag, {4'b0101, w[3:0]},  4'h0, 1'b0, 1'b0, 12'h0);
  endtask

  task automatic rd_mem(input string tag, input logic [11:0] a, input logic [11:0] w);
    send({2'b10, a[11:6]});
    send({2'b11, a[5:0]});
    beat({tag, ".hi"},  8'h00, w[11:8], 1'b0, 1'b0, 12'h0);
    beat({tag, ".mid"}, 8'h20, w[7:4],  1'b0, 1'b0, 12'h0);
    beat({tag, ".lo"},  8'h40, w[3:0],  1'b0, 1'b0, 12'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".data_out"}, 12'(data_out), 12'h0);
    check({tag, ".io_dev"},   12'(io_dev),   12'h0);
    check({tag, ".io_rd"},    12'(io_rd),    12'h0);
    check({tag, ".io_wr"},    12'(io_wr),    12'h0);
    check({tag, ".io_wdata"}, io_wdata,      12'h0);
    check({tag, ".bus_err"},  12'(bus_err),  12'h0);
  endtask

  initial begin
    #3;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Memory write/read, including word 0 for the later IO-write check.
    send(8'h80); send(8'hC5);
    beat("w5.hi",  8'h1A, 4'h0, 1'b0, 1'b0, 12'h0);
    beat("w5.mid", 8'h3B, 4'h0, 1'b0, 1'b0, 12'h0);
    beat("w5.lo",  8'h5C, 4'h0, 1'b0, 1'b0, 12'h0);
    rd_mem("r5", 12'h005, 12'hABC);
    check("r5.bus_err", 12'(bus_err), 12'h0);
    wr_mem("w0", 12'h000, 12'h321);
    rd_mem("r0", 12'h000, 12'h321);

    // IO read
    io_ready = 1'b1;
    io_rdata = 12'h123;
    send(8'h80); send(8'hC0);
    beat("ior.intro", 8'h64, 4'h1, 1'b0, 1'b0, 12'h0);
    check("ior.io_dev", 12'(io_dev), 12'h004);
    beat("ior.hi",  8'h00, 4'h1, 1'b0, 1'b0, 12'h0);
    beat("ior.mid", 8'h20, 4'h2, 1'b0, 1'b0, 12'h0);
    beat("ior.lo",  8'h40, 4'h3, 1'b1, 1'b0, 12'h0);

    // IO write; device not ready this time
    io_ready = 1'b0;
    send(8'h80); send(8'hC0);
    beat("iow.intro", 8'h67, 4'h0, 1'b0, 1'b0, 12'h0);
    beat("iow.hi",  8'h17, 4'h0, 1'b0, 1'b0, 12'h0);
    beat("iow.mid", 8'h37, 4'h0, 1'b0, 1'b0, 12'h0);
    beat("iow.lo",  8'h57, 4'h0, 1'b0, 1'b1, 12'h777);
    check("iow.io_dev", 12'(io_dev), 12'h007);
    rd_mem("iow.mem0", 12'h000, 12'h321);
    check("iow.bus_err", 12'(bus_err), 12'h0);

    // Address wrap: 0x103 aliases 0x003
    wr_mem("wrap.w", 12'h103, 12'h555);
    rd_mem("wrap.r", 12'h003, 12'h555);
    check("wrap.bus_err", 12'(bus_err), 12'h0);

    // Protocol error in IDLE, then a normal read of 0x040
    wr_mem("w40", 12'h040, 12'h9E7);
    beat("err.c3", 8'hC3, 4'h0, 1'b0, 1'b0, 12'h0);
    check("err.bus_err", 12'(bus_err), 12'h1);
    rd_mem("err.r40", 12'h040, 12'h9E7);
    check("err.sticky", 12'(bus_err), 12'h1);

    // Reset during a write to 9 discards it
    wr_mem("w9", 12'h009, 12'h456);
    send(8'h80); send(8'hC9);
    beat("rst.hi", 8'h1F, 4'h0, 1'b0, 1'b0, 12'h0);
    bus_in = 8'h57;
    reset = 1'b0;
    #2;
    check_all_zero("rst.mid");
    @(posedge clk); #1;
    check_all_zero("rst.hold");
    reset = 1'b1;
    rd_mem("rst.r9", 12'h009, 12'h456);
    check("rst.bus_err", 12'(bus_err), 12'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
